axi_master_bridge: RTL and testbench

Single-outstanding AXI3 master that turns simple system-bus read/write requests into single-beat 64-bit AXI3 transactions. It is the initiator-side counterpart of our AXI slave bridge. Acquisition logic uses it to push samples to, and fetch descriptors from, memory through a PS HP/GP slave port. One transaction is in flight at a time; completion is returned as a one-cycle ack with a registered error flag and read data.

---
 rtl/axi_master_bridge.sv | 196 +++++++++++++++++++
 tb/tb_axi_master_bridge.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_bridge.sv
// Single-outstanding AXI3 master: turns one system-bus read/write request
// into a single-beat 64-bit AXI3 transaction and returns a one-cycle ack.
module axi_master_bridge #(
  parameter int          AXI_DW = 64,
  parameter int          AXI_AW = 32,
  parameter int          AXI_IW = 8,
  parameter int unsigned AXI_ID = 0
)(
  input  logic                  axi_clk_i,
  input  logic                  axi_rstn_i,
  // system bus
  input  logic [AXI_AW-1:0]     req_addr_i,
  input  logic [AXI_DW-1:0]     req_wdata_i,
  input  logic [AXI_DW/8-1:0]   req_sel_i,
  input  logic                  req_wen_i,
  input  logic                  req_ren_i,
  output logic [AXI_DW-1:0]     req_rdata_o,
  output logic                  req_err_o,
  output logic                  req_ack_o,
  output logic                  req_busy_o,
  // AW
  output logic [AXI_IW-1:0]     axi_awid_o,
  output logic [AXI_AW-1:0]     axi_awaddr_o,
  output logic [3:0]            axi_awlen_o,
  output logic [2:0]            axi_awsize_o,
  output logic [1:0]            axi_awburst_o,
  output logic [1:0]            axi_awlock_o,
  output logic [3:0]            axi_awcache_o,
  output logic [2:0]            axi_awprot_o,
  output logic                  axi_awvalid_o,
  input  logic                  axi_awready_i,
  // W
  output logic [AXI_IW-1:0]     axi_wid_o,
  output logic [AXI_DW-1:0]     axi_wdata_o,
  output logic [AXI_DW/8-1:0]   axi_wstrb_o,
  output logic                  axi_wlast_o,
  output logic                  axi_wvalid_o,
  input  logic                  axi_wready_i,
  // B
  input  logic [AXI_IW-1:0]     axi_bid_i,
  input  logic [1:0]            axi_bresp_i,
  input  logic                  axi_bvalid_i,
  output logic                  axi_bready_o,
  // AR
  output logic [AXI_IW-1:0]     axi_arid_o,
  output logic [AXI_AW-1:0]     axi_araddr_o,
  output logic [3:0]            axi_arlen_o,
  output logic [2:0]            axi_arsize_o,
  output logic [1:0]            axi_arburst_o,
  output logic [1:0]            axi_arlock_o,
  output logic [3:0]            axi_arcache_o,
  output logic [2:0]            axi_arprot_o,
  output logic                  axi_arvalid_o,
  input  logic                  axi_arready_i,
  // R
  input  logic [AXI_IW-1:0]     axi_rid_i,
  input  logic [AXI_DW-1:0]     axi_rdata_i,
  input  logic [1:0]            axi_rresp_i,
  input  logic                  axi_rlast_i,
  input  logic                  axi_rvalid_i,
  output logic                  axi_rready_o
);

  localparam logic [AXI_IW-1:0] ID = AXI_IW'(AXI_ID);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA} state_t;

  typedef struct packed {
    logic [AXI_AW-1:0]   addr;
    logic [AXI_DW-1:0]   wdata;
    logic [AXI_DW/8-1:0] sel;
  } req_t;

  state_t state, state_n;
  req_t   req_q;
  logic   aw_done, w_done;
  logic   aw_fire, w_fire;

  // Low address bits never reach the bus; beats are always 8-byte aligned.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr_i[2:0];

  // Fixed single-beat INCR attributes.
  assign axi_awid_o    = ID;
  assign axi_wid_o     = ID;
  assign axi_arid_o    = ID;
  assign axi_awlen_o   = 4'd0;
  assign axi_arlen_o   = 4'd0;
  assign axi_awsize_o  = 3'd3;
  assign axi_arsize_o  = 3'd3;
  assign axi_awburst_o = 2'b01;
  assign axi_arburst_o = 2'b01;
  assign axi_awlock_o  = 2'b00;
  assign axi_arlock_o  = 2'b00;
  assign axi_awcache_o = 4'b0011;
  assign axi_arcache_o = 4'b0011;
  assign axi_awprot_o  = 3'b000;
  assign axi_arprot_o  = 3'b000;
  assign axi_wlast_o   = 1'b1;

  // Payload comes straight from the request register, so it is stable while valid.
  assign axi_awaddr_o  = req_q.addr;
  assign axi_araddr_o  = req_q.addr;
  assign axi_wdata_o   = req_q.wdata;
  assign axi_wstrb_o   = req_q.sel;

  // State register.
  always_ff @(posedge axi_clk_i) begin
    if (!axi_rstn_i) state <= IDLE;
    else             state <= state_n;
  end

  // Next state and channel valid/ready decode; valids depend only on registered state.
  always_comb begin
    state_n       = state;
    axi_awvalid_o = 1'b0;
    axi_wvalid_o  = 1'b0;
    axi_bready_o  = 1'b0;
    axi_arvalid_o = 1'b0;
    axi_rready_o  = 1'b0;
    req_busy_o    = (state != IDLE);
    if (state == WR) begin
      axi_awvalid_o = ~aw_done;
      axi_wvalid_o  = ~w_done;
    end
    aw_fire = axi_awvalid_o & axi_awready_i;
    w_fire  = axi_wvalid_o  & axi_wready_i;
    case (state)
      IDLE: begin
        if (req_wen_i && !req_ren_i)      state_n = WR;
        else if (req_ren_i && !req_wen_i) state_n = RD_ADDR;
      end
      WR: if ((aw_done || aw_fire) && (w_done || w_fire)) state_n = WR_RESP;
      WR_RESP: begin
        axi_bready_o = 1'b1;
        if (axi_bvalid_i) state_n = IDLE;
      end
      RD_ADDR: begin
        axi_arvalid_o = 1'b1;
        if (axi_arready_i) state_n = RD_DATA;
      end
      RD_DATA: begin
        axi_rready_o = 1'b1;
        if (axi_rvalid_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Request capture, per-channel done flags and registered completion.
  always_ff @(posedge axi_clk_i) begin
    if (!axi_rstn_i) begin
      req_q       <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      req_ack_o   <= 1'b0;
      req_err_o   <= 1'b0;
      req_rdata_o <= '0;
    end else begin
      req_ack_o <= 1'b0;
      req_err_o <= 1'b0;
      case (state)
        IDLE: begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (req_wen_i && req_ren_i) begin
            // Ambiguous request: refuse without touching the bus.
            req_ack_o <= 1'b1;
            req_err_o <= 1'b1;
          end else if (req_wen_i) begin
            req_q.addr  <= {req_addr_i[AXI_AW-1:3], 3'b000};
            req_q.wdata <= req_wdata_i;
            req_q.sel   <= req_sel_i;
          end else if (req_ren_i) begin
            req_q.addr  <= {req_addr_i[AXI_AW-1:3], 3'b000};
          end
        end
        WR: begin
          if (aw_fire) aw_done <= 1'b1;
          if (w_fire)  w_done  <= 1'b1;
        end
        WR_RESP: if (axi_bvalid_i) begin
          req_ack_o <= 1'b1;
          req_err_o <= axi_bresp_i[1] | (axi_bid_i != ID);
        end
        RD_DATA: if (axi_rvalid_i) begin
          req_ack_o   <= 1'b1;
          req_err_o   <= axi_rresp_i[1] | ~axi_rlast_i | (axi_rid_i != ID);
          req_rdata_o <= axi_rdata_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_master_bridge.sv
// Randomized bench for axi_master_bridge: the bench plays the AXI slave with
// random ready/response delays and checks against a cycle-counted transaction model.
module tb_axi_master_bridge;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_sel;
  logic        req_wen, req_ren;
  logic [63:0] req_rdata;
  logic        req_err, req_ack, req_busy;
  logic [7:0]  awid, wid, arid, bid, rid;
  logic [31:0] awaddr, araddr;
  logic [3:0]  awlen, arlen, awcache, arcache;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, awlock, arlock, bresp, rresp;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_master_bridge dut (
    .axi_clk_i(clk), .axi_rstn_i(rstn),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_sel_i(req_sel),
    .req_wen_i(req_wen), .req_ren_i(req_ren), .req_rdata_o(req_rdata),
    .req_err_o(req_err), .req_ack_o(req_ack), .req_busy_o(req_busy),
    .axi_awid_o(awid), .axi_awaddr_o(awaddr), .axi_awlen_o(awlen), .axi_awsize_o(awsize),
    .axi_awburst_o(awburst), .axi_awlock_o(awlock), .axi_awcache_o(awcache),
    .axi_awprot_o(awprot), .axi_awvalid_o(awvalid), .axi_awready_i(awready),
    .axi_wid_o(wid), .axi_wdata_o(wdata), .axi_wstrb_o(wstrb), .axi_wlast_o(wlast),
    .axi_wvalid_o(wvalid), .axi_wready_i(wready),
    .axi_bid_i(bid), .axi_bresp_i(bresp), .axi_bvalid_i(bvalid), .axi_bready_o(bready),
    .axi_arid_o(arid), .axi_araddr_o(araddr), .axi_arlen_o(arlen), .axi_arsize_o(arsize),
    .axi_arburst_o(arburst), .axi_arlock_o(arlock), .axi_arcache_o(arcache),
    .axi_arprot_o(arprot), .axi_arvalid_o(arvalid), .axi_arready_i(arready),
    .axi_rid_i(rid), .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rlast_i(rlast),
    .axi_rvalid_i(rvalid), .axi_rready_o(rready)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic slave_idle();
    awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
    arready = 0; rvalid = 0; rid = 0; rresp = 0; rlast = 0; rdata = 0;
  endtask

  // Write: slave raises AWREADY/WREADY after awd/wd cycles, BVALID bd cycles
  // after both handshakes. poke>0 pulses a stray read request in that cycle.
  task automatic do_wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                       input int awd, input int wd, input int bd,
                       input logic [1:0] br, input logic [7:0] bidv,
                       input int poke, input int exp_lat);
    bit   aw_ok = 0, w_ok = 0, b_ok = 0, acked = 0;
    int   both_k = -1, k = 0, ack_k = -1;
    logic exp_err;
    exp_err = br[1] | (bidv != 8'h00);
    req_addr = a; req_wdata = d; req_sel = s; req_wen = 1; req_ren = 0;
    @(negedge clk); req_wen = 0; k = 1;
    while (!acked && k < 100) begin
      req_ren = (k == poke);
      awready = (k - 1 >= awd);
      wready  = (k - 1 >= wd);
      bvalid  = (both_k > 0) && (k - both_k >= bd);
      bid = bidv; bresp = br;
      if (b_ok) begin
        chk("wr_ack", req_ack, 1);
        chk("wr_err", req_err, exp_err);
        chk("wr_busy_at_ack", req_busy, 0);
        acked = 1; ack_k = k;
      end else begin
        chk("wr_ack_early", req_ack, 0);
        chk("wr_busy", req_busy, 1);
        chk("awvalid", awvalid, !aw_ok);
        chk("wvalid", wvalid, !w_ok);
        chk("bready", bready, (both_k > 0) && (k >= both_k));
        chk("wr_arvalid", arvalid, 0);
        if (awvalid) chk("awaddr", awaddr, {a[31:3], 3'b000});
        if (wvalid) begin
          chk("wdata", wdata, d);
          chk("wstrb", wstrb, s);
          chk("wlast", wlast, 1);
        end
        if (awvalid && awready) aw_ok = 1;
        if (wvalid && wready)   w_ok = 1;
        if (bvalid && bready)   b_ok = 1;
        if (aw_ok && w_ok && both_k < 0) both_k = k + 1;
      end
      @(negedge clk); k++;
    end
    req_ren = 0; slave_idle();
    chk("wr_completed", acked, 1);
    if (exp_lat > 0) chk("wr_latency", ack_k, exp_lat);
    chk("wr_ack_one_cycle", req_ack, 0);
  endtask

  // Read: ARREADY after ard cycles, RVALID rd cycles after the AR handshake.
  task automatic do_rd(input logic [31:0] a, input logic [63:0] d,
                       input int ard, input int rd, input logic [1:0] rr,
                       input logic rl, input logic [7:0] ridv,
                       input int poke, input int exp_lat);
    bit   ar_ok = 0, r_ok = 0, acked = 0;
    int   ar_k = -1, k = 0, ack_k = -1;
    logic exp_err;
    exp_err = rr[1] | ~rl | (ridv != 8'h00);
    req_addr = a; req_ren = 1; req_wen = 0;
    @(negedge clk); req_ren = 0; k = 1;
    while (!acked && k < 100) begin
      req_wen = (k == poke);
      arready = (k - 1 >= ard);
      rvalid  = (ar_k > 0) && (k - ar_k >= rd);
      rdata = d; rresp = rr; rlast = rl; rid = ridv;
      if (r_ok) begin
        chk("rd_ack", req_ack, 1);
        chk("rd_err", req_err, exp_err);
        chk("rd_data", req_rdata, d);
        chk("rd_busy_at_ack", req_busy, 0);
        acked = 1; ack_k = k;
      end else begin
        chk("rd_ack_early", req_ack, 0);
        chk("rd_busy", req_busy, 1);
        chk("arvalid", arvalid, !ar_ok);
        chk("rready", rready, (ar_k > 0) && (k >= ar_k));
        chk("rd_awvalid", awvalid, 0);
        chk("rd_wvalid", wvalid, 0);
        if (arvalid) chk("araddr", araddr, {a[31:3], 3'b000});
        if (arvalid && arready) begin ar_ok = 1; ar_k = k + 1; end
        if (rvalid && rready) r_ok = 1;
      end
      @(negedge clk); k++;
    end
    req_wen = 0; slave_idle();
    chk("rd_completed", acked, 1);
    if (exp_lat > 0) chk("rd_latency", ack_k, exp_lat);
    chk("rd_ack_one_cycle", req_ack, 0);
  endtask

  initial begin
    rstn = 0; req_addr = 0; req_wdata = 0; req_sel = 0; req_wen = 0; req_ren = 0;
    slave_idle();
    repeat (3) @(negedge clk);
    rstn = 1;
    @(negedge clk);
    chk("rst_ack", req_ack, 0);
    chk("rst_busy", req_busy, 0);
    chk("rst_rdata", req_rdata, 0);
    chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("const_attrs", {awlen, awsize, awburst, awcache, arlen, arsize, arburst, arcache},
        {4'd0, 3'd3, 2'b01, 4'b0011, 4'd0, 3'd3, 2'b01, 4'b0011});

    // Directed cases.
    do_wr(32'h0000_1008, 64'h1122334455667788, 8'hF0, 0, 0, 0, 2'b00, 8'h00, 0, 3);
    do_wr(32'h0000_2010, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 5, 0, 0, 2'b00, 8'h00, 0, 0);
    do_rd(32'h4000_0010, 64'hDEADBEEFCAFEF00D, 0, 0, 2'b00, 1'b1, 8'h00, 0, 3);
    do_rd(32'h4000_0010, 64'hDEADBEEFCAFEF00D, 0, 0, 2'b10, 1'b1, 8'h00, 0, 0);
    do_rd(32'h4000_0018, 64'h0123456789ABCDEF, 1, 1, 2'b00, 1'b0, 8'h00, 0, 0);
    do_rd(32'h4000_0020, 64'h0F1E2D3C4B5A6978, 0, 2, 2'b00, 1'b1, 8'h07, 0, 0);
    do_wr(32'h0000_3007, 64'h0, 8'h01, 0, 2, 1, 2'b11, 8'h00, 0, 0);
    do_wr(32'h0000_4000, 64'h5, 8'h0F, 2, 2, 3, 2'b00, 8'h00, 2, 0);
    do_rd(32'h4000_0040, 64'h77, 3, 3, 2'b00, 1'b1, 8'h00, 2, 0);

    // Simultaneous read and write request: refused, no bus traffic.
    req_wen = 1; req_ren = 1; req_addr = 32'h100;
    @(negedge clk); req_wen = 0; req_ren = 0;
    chk("both_ack", req_ack, 1);
    chk("both_err", req_err, 1);
    chk("both_busy", req_busy, 0);
    for (int i = 0; i < 3; i++) begin
      chk("both_no_valid", {awvalid, wvalid, arvalid}, 0);
      @(negedge clk);
    end
    chk("both_ack_gone", req_ack, 0);

    // Reset while waiting for BVALID, then a normal read.
    req_addr = 32'h8; req_wdata = 64'h99; req_sel = 8'hFF; req_wen = 1;
    @(negedge clk); req_wen = 0; awready = 1; wready = 1;
    @(negedge clk); awready = 0; wready = 0;
    chk("pre_rst_bready", bready, 1);
    rstn = 0;
    @(negedge clk);
    chk("mid_rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("mid_rst_busy", req_busy, 0);
    chk("mid_rst_ack", {req_ack, req_err}, 0);
    chk("mid_rst_rdata", req_rdata, 0);
    rstn = 1;
    @(negedge clk);
    do_rd(32'h4000_0010, 64'hDEADBEEFCAFEF00D, 0, 0, 2'b00, 1'b1, 8'h00, 0, 3);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] idv;
      idv = ($urandom_range(0, 7) == 0) ? 8'h05 : 8'h00;
      if ($urandom_range(0, 1) == 1)
        do_wr($urandom, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 4),
              $urandom_range(0, 4), $urandom_range(0, 4), 2'($urandom), idv,
              $urandom_range(0, 3), 0);
      else
        do_rd($urandom, {$urandom, $urandom}, $urandom_range(0, 4), $urandom_range(0, 4),
              2'($urandom), ($urandom_range(0, 5) != 0), idv, $urandom_range(0, 3), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
